// File: rtl/pattern_serializer.sv
// pattern_serializer: multi-channel run-time-loadable pattern store with an
// MSB-first serializer, programmable bit period, single or repeating frames.
//
// Ports
//   CLK, RST_N      clock (rising edge) / asynchronous active-low reset
//   LOAD            write LOAD_DATA/LOAD_LEN into channel LOAD_CH
//   LOAD_CH         target channel of LOAD
//   LOAD_DATA       right-aligned pattern, bits [len-1:0] significant
//   LOAD_LEN        pattern length in bits (values above MAXLEN clamp)
//   CH_SEL          channel transmitted on START
//   DIV             bit period = DIV+1 clock cycles
//   REPEAT          continuous transmission when 1
//   START           single-cycle transmit request
//   ABORT           stop transmission immediately, no DONE
//   SER_OUT         serial data (0 when SER_VALID is 0)
//   SER_VALID       SER_OUT carries a pattern bit
//   BUSY            transmission in progress
//   DONE            one-cycle pulse per completed frame
module pattern_serializer #(
    parameter int unsigned       NCH         = 2,
    parameter int unsigned       CHW         = 1,
    parameter int unsigned       MAXLEN      = 88,
    parameter int unsigned       LENW        = 7,
    parameter int unsigned       DIVW        = 24,
    parameter logic [MAXLEN-1:0] DEFAULT_PAT = 88'h123456789ABCDEF1234567,
    parameter int unsigned       DEFAULT_LEN = 88
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD,
    input  logic [CHW-1:0]    LOAD_CH,
    input  logic [MAXLEN-1:0] LOAD_DATA,
    input  logic [LENW-1:0]   LOAD_LEN,
    input  logic [CHW-1:0]    CH_SEL,
    input  logic [DIVW-1:0]   DIV,
    input  logic              REPEAT,
    input  logic              START,
    input  logic              ABORT,
    output logic              SER_OUT,
    output logic              SER_VALID,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [LENW-1:0] MAXLEN_L      = LENW'(MAXLEN);
    localparam logic [LENW-1:0] DEFAULT_LEN_L = LENW'(DEFAULT_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Left-align a right-aligned pattern so the first bit to send is the MSB.
    function automatic logic [MAXLEN-1:0] align(input logic [MAXLEN-1:0] p,
                                                input logic [LENW-1:0]   n);
        return p << (MAXLEN_L - n);
    endfunction

    // Pattern store
    logic [MAXLEN-1:0] pat_mem [NCH];
    logic [LENW-1:0]   len_mem [NCH];

    logic            load_ok_c;
    logic [LENW-1:0] load_len_c;

    assign load_ok_c  = LOAD && (32'(LOAD_CH) < NCH);
    assign load_len_c = (LOAD_LEN > MAXLEN_L) ? MAXLEN_L : LOAD_LEN;

    // Pattern/length registers, writable in any state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NCH); i++) begin
                pat_mem[i] <= DEFAULT_PAT;
                len_mem[i] <= DEFAULT_LEN_L;
            end
        end else if (load_ok_c) begin
            pat_mem[LOAD_CH] <= LOAD_DATA;
            len_mem[LOAD_CH] <= load_len_c;
        end
    end

    // Transmitter state
    state_t            state;
    logic [MAXLEN-2:0] work;      // bits still to send after the one on SER_OUT
    logic [LENW-1:0]   wlen;
    logic [LENW-1:0]   bit_cnt;
    logic [DIVW-1:0]   wdiv;
    logic [DIVW-1:0]   div_cnt;
    logic              wrep;
    logic [CHW-1:0]    wch;

    logic              sel_ok_c;
    logic [MAXLEN-1:0] sel_work_c;
    logic [MAXLEN-1:0] rel_work_c;
    logic              bit_end_c;
    logic              frame_end_c;

    assign sel_ok_c    = 32'(CH_SEL) < NCH;
    assign sel_work_c  = align(pat_mem[CH_SEL], len_mem[CH_SEL]);
    // Repeat reload reads the channel's current contents, so mid-frame loads land here
    assign rel_work_c  = align(pat_mem[wch], len_mem[wch]);
    assign bit_end_c   = (div_cnt == wdiv);
    assign frame_end_c = bit_end_c && (bit_cnt == wlen - LENW'(1));

    // Serializer FSM with registered outputs; ABORT overrides everything else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            work      <= '0;
            wlen      <= '0;
            bit_cnt   <= '0;
            wdiv      <= '0;
            div_cnt   <= '0;
            wrep      <= 1'b0;
            wch       <= '0;
            SER_OUT   <= 1'b0;
            SER_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (ABORT) begin
                state     <= IDLE;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                SER_OUT   <= 1'b0;
                SER_VALID <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START && sel_ok_c) begin
                            if (len_mem[CH_SEL] == '0) begin
                                // Empty pattern: complete immediately without sending
                                DONE <= 1'b1;
                            end else begin
                                state                <= SHIFT;
                                {SER_OUT, work}      <= sel_work_c;
                                wlen                 <= len_mem[CH_SEL];
                                wdiv                 <= DIV;
                                wrep                 <= REPEAT;
                                wch                  <= CH_SEL;
                                div_cnt              <= '0;
                                bit_cnt              <= '0;
                                SER_VALID            <= 1'b1;
                                BUSY                 <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (!bit_end_c) begin
                            div_cnt <= div_cnt + DIVW'(1);
                        end else begin
                            div_cnt <= '0;
                            if (!frame_end_c) begin
                                {SER_OUT, work} <= {work, 1'b0};
                                bit_cnt         <= bit_cnt + LENW'(1);
                            end else begin
                                DONE    <= 1'b1;
                                bit_cnt <= '0;
                                if (wrep && (len_mem[wch] != '0)) begin
                                    {SER_OUT, work} <= rel_work_c;
                                    wlen            <= len_mem[wch];
                                end else begin
                                    state     <= IDLE;
                                    SER_OUT   <= 1'b0;
                                    SER_VALID <= 1'b0;
                                    BUSY      <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed and randomized checks of pattern_serializer
// against a bit-list reference model of the stored patterns.
module tb_pattern_serializer;

    localparam int unsigned       NCH         = 2;
    localparam int unsigned       CHW         = 1;
    localparam int unsigned       MAXLEN      = 88;
    localparam int unsigned       LENW        = 7;
    localparam int unsigned       DIVW        = 24;
    localparam logic [MAXLEN-1:0] DEFAULT_PAT = 88'h123456789ABCDEF1234567;
    localparam int unsigned       DEFAULT_LEN = 88;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [CHW-1:0]    load_ch;
    logic [MAXLEN-1:0] load_data;
    logic [LENW-1:0]   load_len;
    logic [CHW-1:0]    ch_sel;
    logic [DIVW-1:0]   div_in;
    logic              repeat_in;
    logic              start;
    logic              abort;
    logic              ser_out;
    logic              ser_valid;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored pattern and length per channel
    logic [MAXLEN-1:0] mpat [NCH];
    int                mlen [NCH];

    pattern_serializer #(
        .NCH(NCH), .CHW(CHW), .MAXLEN(MAXLEN), .LENW(LENW), .DIVW(DIVW),
        .DEFAULT_PAT(DEFAULT_PAT), .DEFAULT_LEN(DEFAULT_LEN)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .LOAD(load), .LOAD_CH(load_ch),
        .LOAD_DATA(load_data), .LOAD_LEN(load_len), .CH_SEL(ch_sel),
        .DIV(div_in), .REPEAT(repeat_in), .START(start), .ABORT(abort),
        .SER_OUT(ser_out), .SER_VALID(ser_valid), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic s, input logic v,
                              input logic b, input logic d);
        chk({tag, " ser_out"},   ser_out,   s);
        chk({tag, " ser_valid"}, ser_valid, v);
        chk({tag, " busy"},      busy,      b);
        chk({tag, " done"},      done,      d);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NCH); i++) begin
            mpat[i] = DEFAULT_PAT;
            mlen[i] = int'(DEFAULT_LEN);
        end
    endtask

    task automatic model_store(input int ch, input logic [MAXLEN-1:0] data, input int len);
        if (ch < int'(NCH)) begin
            mpat[ch] = data;
            mlen[ch] = (len > int'(MAXLEN)) ? int'(MAXLEN) : len;
        end
    endtask

    task automatic do_load(input int ch, input logic [MAXLEN-1:0] data, input int len);
        load      = 1'b1;
        load_ch   = CHW'(ch);
        load_data = data;
        load_len  = LENW'(len);
        tick();
        load = 1'b0;
        model_store(ch, data, len);
    endtask

    // Issue START; afterwards scramble DIV/REPEAT to show they were captured
    task automatic start_tx(input int ch, input int div, input logic rep);
        ch_sel    = CHW'(ch);
        div_in    = DIVW'(div);
        repeat_in = rep;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        div_in    = DIVW'($urandom_range(0, 7));
        repeat_in = 1'($urandom_range(0, 1));
    endtask

    // Check one frame of channel ch cycle by cycle from its first bit, with
    // optional LOAD, ABORT or extra START injected at a given cycle index.
    task automatic check_frame(input int ch, input int div, input logic done_first,
                               input int load_at, input int l_ch,
                               input logic [MAXLEN-1:0] l_data, input int l_len,
                               input int abort_at, input int start_at);
        logic [MAXLEN-1:0] p;
        int                n;
        int                cyc;
        bit                aborted;
        p       = mpat[ch];
        n       = mlen[ch];
        cyc     = 0;
        aborted = 1'b0;
        for (int i = n - 1; i >= 0 && !aborted; i--) begin
            for (int d = 0; d <= div && !aborted; d++) begin
                expect_out("frame", p[i], 1'b1, 1'b1, done_first && (cyc == 0));
                if (cyc == load_at) begin
                    load      = 1'b1;
                    load_ch   = CHW'(l_ch);
                    load_data = l_data;
                    load_len  = LENW'(l_len);
                end
                if (cyc == start_at) begin
                    ch_sel = CHW'($urandom_range(0, NCH - 1));
                    start  = 1'b1;
                end
                if (cyc == abort_at) abort = 1'b1;
                tick();
                load  = 1'b0;
                start = 1'b0;
                if (cyc == abort_at) begin
                    abort   = 1'b0;
                    aborted = 1'b1;
                end
                cyc++;
            end
        end
        if (load_at >= 0) model_store(l_ch, l_data, l_len);
    endtask

    initial begin
        logic [95:0]       r96;
        logic [MAXLEN-1:0] data;
        int                ch;
        int                len;
        int                div;
        int                sel;

        rst_n = 1'b0; load = 1'b0; load_ch = '0; load_data = '0; load_len = '0;
        ch_sel = '0; div_in = '0; repeat_in = 1'b0; start = 1'b0; abort = 1'b0;
        model_reset();

        // Reset state
        tick(); tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Default pattern, one bit per clock
        start_tx(0, 0, 1'b0);
        check_frame(0, 0, 1'b0, -1, 0, '0, 0, -1, -1);
        expect_out("default done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("default after", 1'b0, 1'b0, 1'b0, 1'b0);

        // 0xABCD len 16 at DIV=3 with an ignored START mid-frame, then back-to-back START
        do_load(1, 88'hABCD, 16);
        start_tx(1, 3, 1'b0);
        check_frame(1, 3, 1'b0, -1, 0, '0, 0, -1, 10);
        expect_out("abcd done", 1'b0, 1'b0, 1'b0, 1'b1);
        start_tx(1, 0, 1'b0);
        check_frame(1, 0, 1'b0, -1, 0, '0, 0, -1, -1);
        expect_out("b2b done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Repeat mode with a mid-frame load to the active channel
        start_tx(1, 0, 1'b1);
        check_frame(1, 0, 1'b0, 4, 1, 88'h00FF, 16, -1, -1);
        check_frame(1, 0, 1'b1, -1, 0, '0, 0, -1, -1);
        check_frame(1, 0, 1'b1, -1, 0, '0, 0, 0, -1);
        expect_out("rep abort", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rep abort after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort on bit 5, then restart from the MSB
        start_tx(0, 0, 1'b0);
        check_frame(0, 0, 1'b0, -1, 0, '0, 0, 5, -1);
        expect_out("abort5", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("abort5 after", 1'b0, 1'b0, 1'b0, 1'b0);
        start_tx(0, 1, 1'b0);
        check_frame(0, 1, 1'b0, -1, 0, '0, 0, -1, -1);
        expect_out("restart done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Zero-length pattern
        do_load(1, 88'h5, 0);
        start_tx(1, 0, 1'b0);
        expect_out("len0 done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("len0 after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Over-long length clamps to MAXLEN
        r96  = {$urandom(), $urandom(), $urandom()};
        data = r96[MAXLEN-1:0];
        do_load(1, data, 100);
        start_tx(1, 0, 1'b0);
        check_frame(1, 0, 1'b0, -1, 0, '0, 0, -1, -1);
        expect_out("len100 done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // ABORT and START together in IDLE
        ch_sel = '0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        expect_out("abort+start", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("abort+start after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized single frames
        for (int k = 0; k < 12; k++) begin
            ch   = int'($urandom_range(0, NCH - 1));
            sel  = int'($urandom_range(0, 9));
            len  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(89, 127))
                                               : int'($urandom_range(1, 40));
            div  = int'($urandom_range(0, 2));
            r96  = {$urandom(), $urandom(), $urandom()};
            data = r96[MAXLEN-1:0];
            do_load(ch, data, len);
            start_tx(ch, div, 1'b0);
            if (mlen[ch] != 0) check_frame(ch, div, 1'b0, -1, 0, '0, 0, -1, -1);
            expect_out("rand done", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            expect_out("rand after", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-frame restores defaults
        do_load(1, 88'h3C3C, 30);
        start_tx(1, 0, 1'b0);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 expect_out("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        model_reset();
        expect_out("post reset", 1'b0, 1'b0, 1'b0, 1'b0);
        start_tx(1, 0, 1'b0);
        check_frame(1, 0, 1'b0, -1, 0, '0, 0, -1, -1);
        expect_out("post reset done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
